// File: rtl/denise_pkg.sv
// rtl/denise_pkg.sv - shared constants and types for the Denise CLUT write scheduler
package denise_pkg;

  localparam logic [8:0] COLORBASE = 9'h180;

  localparam int BANK_W = 3;
  localparam int IDX_W  = 5;
  localparam int DAT_W  = 12;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [IDX_W-1:0]  idx;
    logic [DAT_W-1:0]  data;
    logic              loct;
  } clut_entry_t;

  localparam int ENT_W = $bits(clut_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BULK_HI = 2'd1,
    ST_BULK_LO = 2'd2,
    ST_DONE    = 2'd3
  } bulk_state_t;

  localparam logic [1:0] WS_BOTH = 2'b11;
  localparam logic [1:0] WS_LO   = 2'b01;

endpackage

// File: rtl/denise_clut_wrfifo.sv
// rtl/denise_clut_wrfifo.sv - synchronous FIFO buffering captured colour register writes
module denise_clut_wrfifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // a push into a full FIFO still lands when the head leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/denise_clut_wrsched.sv
// rtl/denise_clut_wrsched.sv - arbitrates CLUT writes between COLORxx bus writes and the bulk palette loader
module denise_clut_wrsched #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [8:0] COLORBASE  = denise_pkg::COLORBASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [11:0] data_in,
  input  logic [2:0]  bank,
  input  logic        loct,
  input  logic        hold,
  input  logic        bulk_start,
  input  logic        bulk_valid,
  input  logic [23:0] bulk_data,
  output logic        bulk_ready,
  output logic        bulk_busy,
  output logic        bulk_done,
  output logic [7:0]  wr_adr,
  output logic [11:0] wr_dat,
  output logic [1:0]  wr_ws,
  output logic        wr_en,
  output logic        overflow
);

  import denise_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             match;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] fifo_head;
  clut_entry_t      push_ent;
  clut_entry_t      head;
  logic             bus_pop;
  logic             slot_free;

  bulk_state_t state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [11:0] lo_q, lo_d;
  logic        issue_hi;
  logic        issue_lo;
  logic        ready_c;

  assign match    = clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]);
  assign push_ent = {bank, reg_address_in[5:1], data_in, loct};
  assign head     = clut_entry_t'(fifo_head);

  // bus writes own the slot whenever anything is buffered
  assign bus_pop   = !fifo_empty && !hold;
  assign slot_free = (fifo_count == '0) && !hold;

  denise_clut_wrfifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (match),
    .push_data (push_ent),
    .pop       (bus_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (match && fifo_full && !bus_pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      lo_q    <= 12'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    issue_hi = 1'b0;
    issue_lo = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bulk_start) begin
          state_d = ST_BULK_HI;
          idx_d   = 8'd0;
        end
      end
      ST_BULK_HI: begin
        ready_c = slot_free;
        if (slot_free && bulk_valid) begin
          issue_hi = 1'b1;
          lo_d     = {bulk_data[19:16], bulk_data[11:8], bulk_data[3:0]};
          state_d  = ST_BULK_LO;
        end
      end
      ST_BULK_LO: begin
        if (slot_free) begin
          issue_lo = 1'b1;
          if (idx_q == 8'hFF) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_BULK_HI;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // gated so the flags read zero during the reset cycle itself, not one edge later
  assign bulk_ready = ready_c && !reset;
  assign bulk_busy  = ((state_q == ST_BULK_HI) || (state_q == ST_BULK_LO)) && !reset;
  assign bulk_done  = (state_q == ST_DONE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_adr <= 8'd0;
      wr_dat <= 12'd0;
      wr_ws  <= 2'b00;
      wr_en  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (bus_pop) begin
        wr_adr <= {head.bank, head.idx};
        wr_dat <= head.data;
        wr_ws  <= head.loct ? WS_LO : WS_BOTH;
        wr_en  <= 1'b1;
      end else if (issue_hi) begin
        wr_adr <= idx_q;
        wr_dat <= {bulk_data[23:20], bulk_data[15:12], bulk_data[7:4]};
        wr_ws  <= WS_BOTH;
        wr_en  <= 1'b1;
      end else if (issue_lo) begin
        wr_adr <= idx_q;
        wr_dat <= lo_q;
        wr_ws  <= WS_LO;
        wr_en  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_denise_clut_wrsched.sv
// tb/tb_denise_clut_wrsched.sv - scoreboard bench for the CLUT write scheduler
module tb_denise_clut_wrsched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic [8:1]  reg_address_in = '0;
  logic [11:0] data_in = '0;
  logic [2:0]  bank = '0;
  logic        loct = 1'b0;
  logic        hold = 1'b0;
  logic        bulk_start = 1'b0;
  logic        bulk_valid = 1'b0;
  logic [23:0] bulk_data = '0;
  logic        bulk_ready;
  logic        bulk_busy;
  logic        bulk_done;
  logic [7:0]  wr_adr;
  logic [11:0] wr_dat;
  logic [1:0]  wr_ws;
  logic        wr_en;
  logic        overflow;

  denise_clut_wrsched dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .bank           (bank),
    .loct           (loct),
    .hold           (hold),
    .bulk_start     (bulk_start),
    .bulk_valid     (bulk_valid),
    .bulk_data      (bulk_data),
    .bulk_ready     (bulk_ready),
    .bulk_busy      (bulk_busy),
    .bulk_done      (bulk_done),
    .wr_adr         (wr_adr),
    .wr_dat         (wr_dat),
    .wr_ws          (wr_ws),
    .wr_en          (wr_en),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [21:0] val;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [21:0] bulk_q[$];
  bus_exp_t    mon_e;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_done = 0;
  int feed_idx = 0;
  bit feed_on = 1'b0;
  bit acc_flag = 1'b0;
  bit load_fin = 1'b0;
  int j;
  int s0;
  int t;
  logic [23:0] fd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] mk(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A};
  endfunction

  always @(posedge clk) cyc++;

  // monitor: bus writes are due at a known cycle, everything else must be the next bulk write
  always @(negedge clk) begin
    if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
      mon_e = bus_q.pop_front();
      check_val("bus_en", 32'(wr_en), 32'd1);
      check_val("bus_wr", 32'({wr_adr, wr_dat, wr_ws}), 32'(mon_e.val));
    end else if (wr_en) begin
      if (bulk_q.size() > 0) check_val("bulk_wr", 32'({wr_adr, wr_dat, wr_ws}), 32'(bulk_q.pop_front()));
      else check_val("spurious_wr", 32'(wr_en), 32'd0);
    end
    if (wr_en) n_strobe++;
    if (bulk_done) n_done++;
  end

  // bulk feeder: valid held high, expectations pushed when a beat is accepted
  always @(negedge clk) begin
    #2;
    if (acc_flag) begin
      acc_flag = 1'b0;
      feed_idx++;
    end
    if (feed_on && feed_idx < 256) begin
      bulk_valid = 1'b1;
      fd = mk(feed_idx);
      bulk_data = fd;
      if (bulk_ready) begin
        acc_flag = 1'b1;
        bulk_q.push_back({feed_idx[7:0], fd[23:20], fd[15:12], fd[7:4], 2'b11});
        bulk_q.push_back({feed_idx[7:0], fd[19:16], fd[11:8], fd[3:0], 2'b01});
      end
    end else begin
      bulk_valid = 1'b0;
    end
    if (bus_q.size() > 0 && bus_q[0].due == cyc + 1) check_val("ready_busq", 32'(bulk_ready), 32'd0);
  end

  task automatic bus_write(input logic [8:0] a9, input logic [11:0] d, input logic [2:0] bk, input logic lc);
    @(negedge clk);
    reg_address_in = a9[8:1];
    data_in = d;
    bank = bk;
    loct = lc;
    clk7_en = 1'b1;
    if (a9[8:6] == 3'b110 && !hold)
      bus_q.push_back('{due: cyc + 2, val: {bk, a9[5:1], d, (lc ? 2'b01 : 2'b11)}});
    @(negedge clk);
    clk7_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load();
    int d0;
    int tt;
    @(negedge clk);
    bulk_start = 1'b1;
    feed_idx = 0;
    acc_flag = 1'b0;
    feed_on = 1'b1;
    @(negedge clk);
    bulk_start = 1'b0;
    d0 = n_done;
    tt = 0;
    while (!bulk_done && tt < 3000) begin
      @(negedge clk);
      tt++;
    end
    check_val("done_timeout", 32'(tt < 3000), 32'd1);
    @(negedge clk);
    check_val("done_pulse_w", 32'(bulk_done), 32'd0);
    check_val("busy_after", 32'(bulk_busy), 32'd0);
    check_val("done_count", 32'(n_done - d0), 32'd1);
    check_val("bulk_left", 32'(bulk_q.size()), 32'd0);
    check_val("feed_count", 32'(feed_idx), 32'd256);
    feed_on = 1'b0;
    load_fin = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_outs", 32'({wr_adr, wr_dat, wr_ws, wr_en, bulk_ready, bulk_busy, bulk_done, overflow}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_outs", 32'({wr_adr, wr_dat, wr_ws, wr_en, bulk_ready, bulk_busy, bulk_done, overflow}), 32'd0);

    // single bus write, full and low-nibble forms
    bus_write(9'h182, 12'hABC, 3'd2, 1'b0);
    bus_write(9'h182, 12'hABC, 3'd2, 1'b1);
    bus_write(9'h1BE, 12'h123, 3'd7, 1'b0);

    // non-colour address
    s0 = n_strobe;
    bus_write(9'h100, 12'h555, 3'd1, 1'b0);
    repeat (4) @(negedge clk);
    check_val("noncolour", 32'(n_strobe - s0), 32'd0);

    // hold and overflow
    @(negedge clk);
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus_write({3'b110, 5'(i), 1'b0}, 12'(i), 3'd0, 1'b0);
      if (i == 4) check_val("ovf_at_full", 32'(overflow), 32'd0);
    end
    check_val("ovf_set", 32'(overflow), 32'd1);
    check_val("hold_nostrobe", 32'(n_strobe - s0), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      bus_q.push_back('{due: cyc + 1 + k, val: {3'd0, 5'(k + 1), 12'(k + 1), 2'b11}});
    s0 = n_strobe;
    hold = 1'b0;
    repeat (8) @(negedge clk);
    check_val("drain_count", 32'(n_strobe - s0), 32'd4);
    check_val("ovf_sticky", 32'(overflow), 32'd1);

    // bulk load, no contention
    load_fin = 1'b0;
    run_load();

    // bulk load with a bus write on every clk7_en
    load_fin = 1'b0;
    fork
      run_load();
      begin
        j = 0;
        while (!load_fin) begin
          bus_write({3'b110, 5'(j), 1'b0}, 12'(j * 37), 3'(j), j[0]);
          j++;
        end
      end
    join
    repeat (4) @(negedge clk);

    // reset mid-load
    @(negedge clk);
    bulk_start = 1'b1;
    feed_idx = 0;
    acc_flag = 1'b0;
    feed_on = 1'b1;
    @(negedge clk);
    bulk_start = 1'b0;
    t = 0;
    while (!(wr_en && wr_ws == 2'b11 && wr_adr == 8'd100) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("reach_idx100", 32'(t < 1000), 32'd1);
    #1;
    reset = 1'b1;
    feed_on = 1'b0;
    bulk_q.delete();
    @(negedge clk);
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_mid_outs", 32'({wr_adr, wr_dat, wr_ws, wr_en, bulk_ready, bulk_busy, bulk_done, overflow}), 32'd0);
    reset = 1'b0;
    s0 = n_strobe;
    repeat (6) @(negedge clk);
    check_val("no_aborted_wr", 32'(n_strobe - s0), 32'd0);
    load_fin = 1'b0;
    run_load();

    repeat (10) @(negedge clk);
    check_val("bus_left", 32'(bus_q.size()), 32'd0);
    check_val("bulk_left_end", 32'(bulk_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/denise_clut_wrsched.md
# denise_clut_wrsched

Write scheduler for the Denise colour lookup tables, including the HAM generator's private palette bank. It captures COLORxx custom-register writes from the register bus and tags each one with the BPLCON3 bank/LOCT state in force when it arrived. It arbitrates the table write port between those writes and a bulk 24-bit palette loader (OSD / state restore), and buffers bus writes while the port is frozen by `hold`. Its outputs drive the CLUT write address, data, nibble-select and enable directly.

## Interface
- `FIFO_DEPTH`, 4: bus-write buffer entries (power of two, ≥2).
- `COLORBASE`, 9'h180: colour register base; a write matches when `reg_address_in[8:6] == COLORBASE[8:6]`.
- `clk` in 1: 28 MHz clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `clk7_en` in 1: 7 MHz enable; bus capture happens only when this is high.
- `reg_address_in` in [8:1]: custom register address.
- `data_in` in 12: register write data.
- `bank` in 3: BPLCON3 colour bank.
- `loct` in 1: BPLCON3 LOCT (low-nibble write).
- `hold` in 1: freezes the write port; no `wr_en` while high.
- `bulk_start` in 1: one-cycle pulse that starts a 256-entry load.
- `bulk_valid` in 1: `bulk_data` is valid.
- `bulk_data` in 24: {R8,G8,B8}.
- `bulk_ready` out 1: `bulk_data` is accepted on a cycle where `bulk_valid` and `bulk_ready` are both high.
- `bulk_busy` out 1: load in progress.
- `bulk_done` out 1: one-cycle pulse after the last entry is written.
- `wr_adr` out 8: CLUT write address.
- `wr_dat` out 12: CLUT write data.
- `wr_ws` out 2: nibble-half enables. 2'b11 writes the high and low halves; 2'b01 writes the low half only.
- `wr_en` out 1: one-cycle write strobe.
- `overflow` out 1: sticky; set when a bus write is dropped.

## Operation
- **Capture.** On a cycle with `clk7_en` high and a matching address, push {`bank`, `reg_address_in[5:1]`, `data_in`, `loct`} into the FIFO. Each entry is 21 bits.
- **Capture when full.** If the FIFO is full, drop the new write and set `overflow`. The FIFO contents are unchanged.
- **Bus issue.** When the FIFO is non-empty and `hold` is low, pop the head. On the next edge, register `wr_adr` = {bank, idx5}, `wr_dat` = data, and `wr_ws` = loct ? 2'b01 : 2'b11, and assert `wr_en`.
- **Slot priority.** The write slot belongs to the bus whenever the FIFO is non-empty. The bulk loader uses a slot only when `slot_free = fifo_empty && !hold`.
- **Bulk FSM states:** IDLE, BULK_HI, BULK_LO, DONE.
- **IDLE.** `bulk_start` moves to BULK_HI with `idx` = 0. `bulk_start` is ignored in every other state.
- **BULK_HI.** `bulk_ready = slot_free` (combinational; it does not depend on `bulk_valid`). On acceptance:
  - latch the low nibbles {d[19:16], d[11:8], d[3:0]};
  - issue `wr_adr` = idx, `wr_dat` = {d[23:20], d[15:12], d[7:4]}, `wr_ws` = 2'b11;
  - go to BULK_LO.
- **BULK_LO.** When `slot_free`, issue `wr_adr` = idx, the latched low nibbles, `wr_ws` = 2'b01. If idx == 255 go to DONE; otherwise idx++ and go to BULK_HI.
- **DONE.** Pulse `bulk_done` for one cycle, then go to IDLE.
- **`bulk_busy`** is high in BULK_HI and BULK_LO.
- **Interleaving.** Bus writes may land between the HI and LO writes of one entry; the last writer wins.
- **Reset.** Reset at any point, including mid-load, returns the block to its reset state:
  - FIFO emptied;
  - FSM to IDLE, idx 0;
  - all outputs 0 (`wr_adr`, `wr_dat`, `wr_ws`, `wr_en`, `bulk_ready`, `bulk_busy`, `bulk_done`, `overflow`);
  - no further writes from the aborted load.

## Timing
- **Bus write latency.** Capture at edge E. `wr_en` is high for exactly the one cycle following edge E+1, provided `hold` was low in the cycle between E and E+1. There is no bypass path.
- **Throughput.** At most one `wr_en` per `clk` cycle. Bus capture is at most one per `clk7_en`, so the FIFO fills only under `hold`.
- **Simultaneous push and pop.** A push and a pop in the same cycle are both honoured and the count is unchanged. A push while full with a simultaneous pop is accepted, not dropped.
- **Bulk write timing.**
  - The HI write strobes on the edge after acceptance.
  - The LO write strobes no earlier than the following edge.
  - A full load takes at least 512 write cycles plus 1 cycle for DONE.
- **`hold` rise** suppresses `wr_en` from the next edge onward. An already-registered strobe completes.

## Structure
- **Shared `denise_pkg`:** `COLORBASE`, FIFO entry field widths, FSM state encoding, and `WS_BOTH` = 2'b11 / `WS_LO` = 2'b01.
- **Sub-module `denise_clut_wrfifo`:** synchronous FIFO with parameterised width and depth, push/pop ports, and full/empty/count outputs.
- **Top level:** capture decode, arbiter, bulk FSM, and output registers.

## Test plan
1. **Single bus write.** `reg_address_in` = 9'h182>>1, `data_in` = 12'hABC, `bank` = 3'd2, `loct` = 0, `clk7_en` pulse → one `wr_en` 2 edges later with `wr_adr` = 8'h41, `wr_dat` = 12'hABC, `wr_ws` = 2'b11; same write with `loct` = 1 → `wr_ws` = 2'b01.
2. **Non-colour address.** Address 9'h100 → no `wr_en`, FIFO stays empty.
3. **Hold and overflow.** With `hold` high, capture 5 writes (data 1..5) → `overflow` = 1, no strobes. Release `hold` → exactly 4 strobes with data 1, 2, 3, 4 on consecutive cycles.
4. **Bulk load, no contention.** `bulk_start`, `bulk_valid` held high, data = {idx, ~idx, idx^8'h5A} → 512 strobes alternating `wr_ws` 11/01 at `wr_adr` 0..255. The entry at idx 255 writes HI = 12'hF0A, then LO = 12'hF05. `bulk_done` pulses once and `bulk_busy` then drops.
5. **Bulk with contention.** Inject bus writes every `clk7_en` during the load → each bus write issues with latency 2, bulk strobes fill only the free slots, `bulk_ready` is low whenever the FIFO is non-empty, and no entry is skipped.
6. **Reset mid-load.** Assert `reset` at idx 100 in BULK_LO → `wr_en` low the following cycle and all outputs 0. A new `bulk_start` afterwards restarts at `wr_adr` 0.
